// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - round-robin issue arbiter and result router for one shared pipelined FPU
//
// Shares one pipelined FPU between NREQ requesters. Grants are round-robin.
// Each granted request is registered into the FPU issue port. A divide
// stalls further issue long enough that its result comes back before any
// later result. Every in-flight op has a slot in a shift-register
// scoreboard, and that slot steers the op's result back to the requester
// that issued it.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low reset
//   flush      - synchronous; drops all queued and in-flight work
//   req_valid  - per-requester request valid
//   req_ready  - per-requester one-hot grant (handshake = valid & ready)
//   req_op     - per-requester opcode, slice i = [3i+2:3i]
//   req_opa    - per-requester operand A, slice i = [32i+31:32i]
//   req_opb    - per-requester operand B, slice i = [32i+31:32i]
//   fpu_start  - one-cycle issue strobe to the FPU
//   fpu_op     - registered opcode
//   fpu_opa    - registered operand A
//   fpu_opb    - registered operand B
//   fpu_result - FPU result bus
//   rsp_valid  - one-hot result strobe toward the owning requester
//   rsp_data   - result data (fpu_result passed through)
//   busy       - ops in flight or divide stall active

module fpu_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int LAT     = 4,
  parameter int DIV_LAT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_opa,
  input  logic [32*NREQ-1:0]   req_opb,
  output logic                 fpu_start,
  output logic [2:0]           fpu_op,
  output logic [31:0]          fpu_opa,
  output logic [31:0]          fpu_opb,
  input  logic [31:0]          fpu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DIV_GAP = DIV_LAT - LAT;
  localparam int CW      = (DIV_GAP > 1) ? $clog2(DIV_GAP + 1) : 1;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic {IDLE, DIV_WAIT} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        stall_cnt;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       cand;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_found;
  logic                 can_issue;
  logic                 hs;
  logic [2:0]           gnt_op;
  logic [31:0]          gnt_opa;
  logic [31:0]          gnt_opb;
  logic [IDW-1:0]       iss_id;

  // Scoreboard: index 0 is the head, which lines up with fpu_result.
  logic [DIV_LAT-1:0]           sb_vld, sb_vld_nxt;
  logic [DIV_LAT-1:0][IDW-1:0]  sb_id, sb_id_nxt;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = IDW'((int'(ptr) + j) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_op  = '0;
    gnt_opa = '0;
    gnt_opb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_op  = req_op[3*i +: 3];
        gnt_opa = req_opa[32*i +: 32];
        gnt_opb = req_opb[32*i +: 32];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (hs && gnt_op == OP_DIV) state_nxt = DIV_WAIT;
        DIV_WAIT: if (stall_cnt == CW'(1))    state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs. Gating on reset keeps grants low while reset is held.
  always_comb begin
    can_issue = reset && !flush && (state == IDLE);
    hs        = can_issue && gnt_found;
    req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Stall counter covers the extra divide latency, so the next issue
  // cannot return a result before or alongside the divide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hs && gnt_op == OP_DIV) begin
      stall_cnt <= CW'(DIV_GAP);
    end else if (state == DIV_WAIT) begin
      stall_cnt <= stall_cnt - 1'b1;
    end
  end

  // Issue register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_start <= 1'b0;
      fpu_op    <= '0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      iss_id    <= '0;
      ptr       <= '0;
    end else begin
      fpu_start <= hs;
      if (hs) begin
        fpu_op  <= gnt_op;
        fpu_opa <= gnt_opa;
        fpu_opb <= gnt_opb;
        iss_id  <= gnt_idx;
        ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Slot LAT-1 (or DIV_LAT-1) after this cycle's shift puts the entry at
  // the head exactly LAT (or DIV_LAT) cycles after fpu_start.
  always_comb begin
    sb_vld_nxt = {1'b0, sb_vld[DIV_LAT-1:1]};
    sb_id_nxt  = '0;
    for (int k = 0; k < DIV_LAT - 1; k++) begin
      sb_id_nxt[k] = sb_id[k+1];
    end
    if (fpu_start) begin
      if (fpu_op == OP_DIV) begin
        sb_vld_nxt[DIV_LAT-1] = 1'b1;
        sb_id_nxt[DIV_LAT-1]  = iss_id;
      end else begin
        sb_vld_nxt[LAT-1] = 1'b1;
        sb_id_nxt[LAT-1]  = iss_id;
      end
    end
    if (flush) begin
      sb_vld_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld <= '0;
      sb_id  <= '0;
    end else begin
      sb_vld <= sb_vld_nxt;
      sb_id  <= sb_id_nxt;
    end
  end

  // A result landing in the flush cycle belongs to flushed work.
  assign rsp_valid = (sb_vld[0] && !flush) ? (NREQ'(1) << sb_id[0]) : '0;
  assign rsp_data  = fpu_result;
  assign busy      = (|sb_vld) || (state == DIV_WAIT);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb/tb_fpu_issue_arbiter.sv - scoreboard testbench for fpu_issue_arbiter

module tb_fpu_issue_arbiter;

  localparam int NREQ    = 2;
  localparam int LAT     = 4;
  localparam int DIV_LAT = 10;
  localparam int GAP     = DIV_LAT - LAT;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [3*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_opa;
  logic [32*NREQ-1:0]  req_opb;
  logic                fpu_start;
  logic [2:0]          fpu_op;
  logic [31:0]         fpu_opa;
  logic [31:0]         fpu_opb;
  logic [31:0]         fpu_result;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                busy;

  fpu_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          expect_rsp = 1'b1;
  bit          pend_iss = 1'b0;
  logic [2:0]  pend_op;
  logic [31:0] pend_a;
  logic [31:0] pend_b;

  function automatic logic [31:0] fmodel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = (req_valid & ~(NREQ'(1) << i)) | (NREQ'(v) << i);
    req_op    = (req_op  & ~((3*NREQ)'(3'h7) << (3*i)))  | ((3*NREQ)'(op) << (3*i));
    req_opa   = (req_opa & ~((32*NREQ)'(32'hffffffff) << (32*i))) | ((32*NREQ)'(a) << (32*i));
    req_opb   = (req_opb & ~((32*NREQ)'(32'hffffffff) << (32*i))) | ((32*NREQ)'(b) << (32*i));
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_op    = '0;
    req_opa   = '0;
    req_opb   = '0;
  endtask

  task automatic do_reset();
    check("queue_drained", 64'(exp_q.size()), 0);
    @(negedge clk);
    clear_reqs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // FPU model: result appears LAT (DIV_LAT) cycles after fpu_start
  task automatic fpu_launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int l;
    l = (op == 3'b011) ? DIV_LAT : LAT;
    fork
      begin
        repeat (l - 1) @(posedge clk);
        fpu_result <= fmodel(op, a, b);
      end
    join_none
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && fpu_start) fpu_launch(fpu_op, fpu_opa, fpu_opb);
  end

  // Monitor: issue checks, scoreboard push on handshake, pop on response
  always @(negedge clk) begin
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    #2;
    if (!reset) begin
      pend_iss = 1'b0;
    end else begin
      if (pend_iss) begin
        check("fpu_start", 64'(fpu_start), 1);
        check("fpu_op", 64'(fpu_op), 64'(pend_op));
        check("fpu_opa", 64'(fpu_opa), 64'(pend_a));
        check("fpu_opb", 64'(fpu_opb), 64'(pend_b));
      end else begin
        check("fpu_start_quiet", 64'(fpu_start), 0);
      end
      pend_iss = 1'b0;
      check("ready_onehot0", 64'($onehot0(req_ready)), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (1'(((req_valid & req_ready) >> i))) begin
          op = 3'(req_op >> (3*i));
          a  = 32'(req_opa >> (32*i));
          b  = 32'(req_opb >> (32*i));
          pend_iss = 1'b1;
          pend_op  = op;
          pend_a   = a;
          pend_b   = b;
          if (expect_rsp)
            exp_q.push_back('{i, fmodel(op, a, b), cyc + 1 + ((op == 3'b011) ? DIV_LAT : LAT)});
        end
      end
      if (rsp_valid != '0) begin
        check("rsp_onehot", 64'($onehot(rsp_valid)), 1);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("rsp_missing", 64'(rsp_valid), 64'(1) << e.id);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    fpu_result = '0;
    clear_reqs();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 64'({req_ready, fpu_start, rsp_valid, busy, fpu_op}), 0);
    check("reset_opa", 64'(fpu_opa), 0);
    check("reset_opb", 64'(fpu_opb), 0);
    @(negedge clk);
    reset = 1'b1;

    // single mul from req0
    @(negedge clk);
    set_req(0, 1'b1, 3'b010, 32'h40000000, 32'h40400000);
    #1 check("t1_ready", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    clear_reqs();
    repeat (LAT + 3) @(negedge clk);

    // both requesters streaming adds: alternating grants from pointer 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, 3'b000, 32'h1000 + k, 32'h2000 + k);
      set_req(1, 1'b1, 3'b000, 32'h3000 + k, 32'h4000 + k);
      #1 check("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    end
    @(negedge clk);
    clear_reqs();
    repeat (LAT + 3) @(negedge clk);

    // div from req1 stalls a waiting add from req0
    do_reset();
    @(negedge clk);
    set_req(1, 1'b1, 3'b011, 32'h3f800000, 32'h40000000);
    #1 check("t3_div_grant", 64'(req_ready), 64'(2'b10));
    @(negedge clk);
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(0, 1'b1, 3'b000, 32'h12345678, 32'h9abcdef0);
    for (int k = 0; k < GAP; k++) begin
      #1 check("t3_stall_ready", 64'(req_ready), 0);
      check("t3_stall_busy", 64'(busy), 1);
      @(negedge clk);
    end
    #1 check("t3_add_grant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    clear_reqs();
    repeat (DIV_LAT + 3) @(negedge clk);

    // three muls then flush: no responses, busy drops, immediate regrant
    expect_rsp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, 3'b010, 32'h5000 + k, 32'h6000 + k);
      #1 check("t4_grant", 64'(req_ready), 64'(2'b01));
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    flush = 1'b1;
    set_req(0, 1'b1, 3'b010, 32'h7777, 32'h8888);
    #1 check("t4_flush_ready", 64'(req_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    expect_rsp = 1'b1;
    #1 check("t4_busy_after_flush", 64'(busy), 0);
    check("t4_regrant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    clear_reqs();
    repeat (LAT + 3) @(negedge clk);

    // asynchronous reset with a div in flight
    expect_rsp = 1'b0;
    @(negedge clk);
    set_req(1, 1'b1, 3'b011, 32'hcafe0000, 32'h0000beef);
    #1 check("t5_div_grant", 64'(req_ready), 64'(2'b10));
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #3;
    reset = 1'b0;
    set_req(0, 1'b1, 3'b000, 32'h1, 32'h2);
    set_req(1, 1'b1, 3'b000, 32'h3, 32'h4);
    #1 check("t5_async_outs", 64'({req_ready, fpu_start, rsp_valid, busy, fpu_op}), 0);
    check("t5_async_opa", 64'(fpu_opa), 0);
    check("t5_async_opb", 64'(fpu_opb), 0);
    @(negedge clk);
    @(negedge clk);
    clear_reqs();
    reset = 1'b1;
    repeat (DIV_LAT + 2) @(negedge clk);
    expect_rsp = 1'b1;
    set_req(0, 1'b1, 3'b001, 32'habc, 32'hdef);
    set_req(1, 1'b1, 3'b001, 32'h123, 32'h456);
    #1 check("t5_ptr_restart", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    clear_reqs();
    repeat (LAT + 4) @(negedge clk);

    // idle
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1 check("t6_idle", 64'({req_ready, fpu_start, rsp_valid, busy}), 0);
    end
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
- Shares one pipelined FPU (pre-normalize, mul/div core, post-normalize) between NREQ requesters.
- Grants requests round-robin and registers the operands and opcode into the FPU.
- Blocks further issue while a divide occupies the divider, so results never collide on the shared result bus.
- Tracks every in-flight operation in a return-slot scoreboard and steers each result back to the requester that issued it.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 4, cycles from fpu_start to fpu_result for add/sub/mul.
- DIV_LAT, 10, cycles from fpu_start to fpu_result for div (fpu_op 3'b011); must be > LAT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous; drops all queued and in-flight work.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; handshake = valid & ready.
- req_op  in  3*NREQ  per-requester fpu_op; slice i = [3i+2:3i].
- req_opa  in  32*NREQ  per-requester operand A.
- req_opb  in  32*NREQ  per-requester operand B.
- fpu_start  out  1  one-cycle issue strobe to the FPU.
- fpu_op  out  3  registered opcode.
- fpu_opa  out  32  registered operand A.
- fpu_opb  out  32  registered operand B.
- fpu_result  in  32  FPU result bus.
- rsp_valid  out  NREQ  one-hot result strobe.
- rsp_data  out  32  result, equal to fpu_result.
- busy  out  1  high while any operation is in flight or DIV_WAIT is active.

Behaviour:
- Reset (reset=0, async): outputs and state clear as follows.
  - fpu_start, req_ready, rsp_valid, busy = 0.
  - fpu_op/opa/opb = 0.
  - Round-robin pointer = 0, scoreboard empty, FSM = IDLE.
- FSM has two states, IDLE and DIV_WAIT.
  - IDLE: req_ready is combinational and one-hot. The grant goes to the first valid requester at or after the pointer, wrapping modulo NREQ. No request pending → req_ready = 0.
  - Handshake at cycle t: the request is registered, so fpu_start = 1 at t+1 with fpu_op/opa/opb from that request. The pointer moves to the granted index + 1 (wraps).
  - Granted op == 3'b011: go to DIV_WAIT and load the stall counter with DIV_LAT-LAT.
  - DIV_WAIT: req_ready = 0. The counter decrements each cycle; when it reaches 1, return to IDLE.
  - Result: the first post-divide issue has fpu_start at least DIV_LAT-LAT+1 cycles after the divide's fpu_start. Its result therefore lands strictly after the divide result.
- Scoreboard: DIV_LAT-entry shift register, one entry per cycle, each entry = {valid, requester id}.
  - On fpu_start, insert at depth LAT for non-div ops or DIV_LAT for div ops.
  - The entry reaches the head exactly when fpu_result is valid.
  - Head valid → rsp_valid[id] = 1 in that cycle; rsp_data = fpu_result (combinational).
  - Never more than one rsp_valid bit high.
- Throughput: back-to-back non-div ops issue one per cycle. LAT-aligned inserts never collide.
- Illegal opcodes (>3'b011) issue normally as non-div with LAT latency. Decoding them is the FPU's concern.
- busy = any scoreboard entry valid OR FSM == DIV_WAIT.
- flush, synchronous, highest priority:
  - Next cycle: scoreboard cleared, FSM = IDLE, fpu_start = 0.
  - req_ready = 0 in the flush cycle.
  - The pointer is kept.
  - Results of flushed ops produce no rsp_valid.
- A handshake and a result return in the same cycle are independent and both take effect.
- Reset mid-operation: in-flight results are dropped and produce no rsp_valid after release.

Test Plan:
- Single mul from req0 (op=3'b010, opa=0x40000000, opb=0x40400000), handshake at t → fpu_start at t+1 with those values; rsp_valid=2'b01 at t+1+LAT, rsp_data = fpu_result.
- Both requesters hold valid continuously with add ops → grants alternate 01,10,01,10 from pointer 0; each response returns to the correct id, in issue order, one per cycle.
- req1 div at t, req0 add waiting → req_ready=0 for DIV_LAT-LAT cycles; add fpu_start at t+1+DIV_LAT-LAT+1; div rsp (id1) at t+1+DIV_LAT precedes add rsp (id0).
- Issue 3 muls back-to-back, assert flush on the cycle after the third fpu_start → no rsp_valid for any of them; busy=0 the cycle after flush; a new request is granted the following cycle.
- Assert reset=0 asynchronously with a div in flight → all outputs 0 immediately; after release, no stale rsp_valid for DIV_LAT cycles; pointer restarts at req0.
- No requests, idle for 20 cycles → req_ready, fpu_start, rsp_valid, busy all remain 0.
